// File: rtl/clk_out_period_meter_pkg.sv
// Shared types and defaults for the divided-clock period meter.
// Pure declarations: no latency, no flow control.
package clk_out_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_out_period_meter_if.sv
// Control and result bundle between the meter and its consumer.
// Plain wires: no latency, no flow control (meas_valid is a one-cycle strobe).
interface clk_out_period_meter_if
  import clk_out_period_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  modport master (
    output en, sig_in,
    input  period, high_time, meas_valid, timeout, busy
  );

  modport slave (
    input  en, sig_in,
    output period, high_time, meas_valid, timeout, busy
  );
endinterface

// File: rtl/clk_out_period_meter_sync_rise_detect.sv
// Synchronizes an asynchronous level into clk and flags its rising edges.
// Latency SYNC_STAGES+1 edges to s/rise; no backpressure.
module sync_rise_detect
  import clk_out_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic rise
);
  // Fewer than two flops would not be a metastability filter, so clamp.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] chain;
  logic              s_d1;
  logic              rise_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain  <= '0;
      s_d1   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      chain  <= {chain[STAGES-2:0], sig_in};
      s_d1   <= chain[STAGES-1];
      rise_q <= chain[STAGES-1] & ~s_d1;
    end
  end

  // s is taken from s_d1 so the level stays cycle-aligned with the registered rise.
  assign s    = s_d1;
  assign rise = rise_q;
endmodule

// File: rtl/clk_out_period_meter.sv
// Measures period and high time of an asynchronous divided clock in clk cycles, with stuck timeout.
// Rise on sig_in -> meas_valid after SYNC_STAGES+2 edges; no backpressure, results overwrite.
module clk_out_period_meter
  import clk_out_period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic                   clk,
  input logic                   rst,
  clk_out_period_meter_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic s;
  logic rise;

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (bus.sig_in),
    .s      (s),
    .rise   (rise)
  );

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             vld_q, vld_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      vld_q     <= vld_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    vld_d     = 1'b0;
    timeout_d = timeout_q;

    // Disable beats everything, including a coincident rise; results hold.
    if (!bus.en) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (rise) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_W'(1);
            hcnt_d  = CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            vld_d    = 1'b1;
            cnt_d    = CNT_W'(1);
            hcnt_d   = CNT_W'(1);
          end else if (cnt_q == CNT_MAX) begin
            // Stuck input: drop the partial period and wait for a fresh edge.
            state_d   = ST_ARM;
            timeout_d = 1'b1;
            cnt_d     = '0;
            hcnt_d    = '0;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            hcnt_d = hcnt_q + CNT_W'(s);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = vld_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = (state_q == ST_MEASURE);
endmodule
